// File: rtl/max_exp_sched_pkg.sv
// Shared types for the max-exponent sequencer: lane count, default exponent
// width, FSM state encoding and the lane unpacking helper.
// The lane helpers are sized by EXP_W_DEF; the top's EXP_W must match it.
package max_exp_pkg;

  localparam int EXP_W_DEF = 6;
  localparam int LANES     = 9;

  typedef logic [EXP_W_DEF-1:0]     exp_t;
  typedef exp_t [LANES-1:0]         lane_arr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Element 0 is lane 1, which sits in the MSB slice of the flat bus.
  function automatic lane_arr_t unpack_lanes(input logic [LANES*EXP_W_DEF-1:0] v);
    lane_arr_t l;
    for (int i = 0; i < LANES; i++) begin
      l[i] = v[(LANES-1-i)*EXP_W_DEF +: EXP_W_DEF];
    end
    return l;
  endfunction

  function automatic exp_t max2(input exp_t a, input exp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max_exp_sched_if.sv
// Handshake bundle between operand fetch, the max-exponent sequencer and the
// alignment stage. slave = sequencer side, master = producer/consumer side.
// Latency and backpressure are defined by the sequencer, not the bundle.
interface max_exp_sched_if #(
  parameter int EXP_W = 6,
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0]   cfg_groups;
  logic               in_valid;
  logic               in_ready;
  logic [9*EXP_W-1:0] in_exp;
  logic [8:0]         in_skip;
  logic               out_valid;
  logic               out_ready;
  logic [EXP_W-1:0]   out_max_exp;
  logic               out_all_skip;
  logic               busy;

  modport slave (
    input  cfg_groups, in_valid, in_exp, in_skip, out_ready,
    output in_ready, out_valid, out_max_exp, out_all_skip, busy
  );

  modport master (
    output cfg_groups, in_valid, in_exp, in_skip, out_ready,
    input  in_ready, out_valid, out_max_exp, out_all_skip, busy
  );
endinterface

// File: rtl/max_exp_sched_max9_tree.sv
// 9-lane skip masking plus unsigned maximum through a balanced 2-input tree.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result with its own handshake.
module max9_tree import max_exp_pkg::*; (
  input  logic [LANES*EXP_W_DEF-1:0] exp_i,
  input  logic [LANES-1:0]           skip_i,
  output logic [EXP_W_DEF-1:0]       max_exp_o,
  output logic                       all_skip_o
);

  lane_arr_t lanes;
  lane_arr_t masked;
  exp_t      m12, m34, m56, m78, m1_4, m5_8, m1_8;

  // Mask skipped lanes to zero, then reduce lanes 1-8 pairwise and fold in lane 9 last.
  always_comb begin
    lanes = unpack_lanes(exp_i);
    for (int i = 0; i < LANES; i++) begin
      masked[i] = skip_i[LANES-1-i] ? '0 : lanes[i];
    end
    m12        = max2(masked[0], masked[1]);
    m34        = max2(masked[2], masked[3]);
    m56        = max2(masked[4], masked[5]);
    m78        = max2(masked[6], masked[7]);
    m1_4       = max2(m12, m34);
    m5_8       = max2(m56, m78);
    m1_8       = max2(m1_4, m5_8);
    max_exp_o  = max2(m1_8, masked[8]);
    all_skip_o = &skip_i;
  end

endmodule

// File: rtl/max_exp_sched.sv
// Folds per-window 9-lane maximum exponents into a block maximum over cfg_groups windows.
// Latency: out_valid 1 cycle after the last accept (2 with MAX_EXP_SCHED_PIPE_EN defined).
// Backpressure: in_ready low outside IDLE/ACCUM; result held in DONE until out_ready.
module max_exp_sched import max_exp_pkg::*; #(
  parameter int EXP_W = EXP_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  max_exp_sched_if.slave     bus
);

`ifdef MAX_EXP_SCHED_PIPE_EN
  localparam state_e END_ST = FLUSH;
`else
  localparam state_e END_ST = DONE;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] groups_q, groups_d;
  logic [EXP_W-1:0] acc_q, acc_d;
  logic             all_skip_q, all_skip_d;

  logic             accept;
  logic [EXP_W-1:0] tree_max;
  logic             tree_all;

  logic             fold_vld;
  logic             fold_first;
  logic [EXP_W-1:0] fold_max;
  logic             fold_all;

  // Gated with rst_n so producers never see ready while reset is held.
  assign bus.in_ready     = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
  assign bus.out_valid    = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.out_max_exp  = acc_q;
  assign bus.out_all_skip = all_skip_q;
  assign accept           = bus.in_valid && bus.in_ready;

  max9_tree u_tree (
    .exp_i      (bus.in_exp),
    .skip_i     (bus.in_skip),
    .max_exp_o  (tree_max),
    .all_skip_o (tree_all)
  );

`ifdef MAX_EXP_SCHED_PIPE_EN
  logic             pipe_vld_q;
  logic             pipe_first_q;
  logic [EXP_W-1:0] pipe_max_q;
  logic             pipe_all_q;

  // Register stage between the compare tree and the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q   <= 1'b0;
      pipe_first_q <= 1'b0;
      pipe_max_q   <= '0;
      pipe_all_q   <= 1'b0;
    end else begin
      pipe_vld_q   <= accept;
      pipe_first_q <= (state_q == IDLE);
      pipe_max_q   <= tree_max;
      pipe_all_q   <= tree_all;
    end
  end

  assign fold_vld   = pipe_vld_q;
  assign fold_first = pipe_first_q;
  assign fold_max   = pipe_max_q;
  assign fold_all   = pipe_all_q;
`else
  assign fold_vld   = accept;
  assign fold_first = (state_q == IDLE);
  assign fold_max   = tree_max;
  assign fold_all   = tree_all;
`endif

  // Next state and group counting; cfg_groups is only looked at on the first window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    groups_d = groups_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          groups_d = (bus.cfg_groups == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : bus.cfg_groups;
          cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d  = (bus.cfg_groups > {{(CNT_W-1){1'b0}}, 1'b1}) ? ACCUM : END_ST;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          // Compare against groups-1 so a full-scale group count never overflows.
          if (cnt_q == groups_q - 1'b1) state_d = END_ST;
        end
      end
      FLUSH:   state_d = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Running block maximum; the first window of a block overwrites stale contents.
  always_comb begin
    acc_d      = acc_q;
    all_skip_d = all_skip_q;
    if (fold_vld) begin
      if (fold_first) begin
        acc_d      = fold_max;
        all_skip_d = fold_all;
      end else begin
        acc_d      = (fold_max > acc_q) ? fold_max : acc_q;
        all_skip_d = all_skip_q & fold_all;
      end
    end
  end

  // State, counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      groups_q   <= '0;
      acc_q      <= '0;
      all_skip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      groups_q   <= groups_d;
      acc_q      <= acc_d;
      all_skip_q <= all_skip_d;
    end
  end

endmodule

// File: tb/tb_max_exp_sched.sv
// Scoreboard bench for max_exp_sched: expected block results are queued as
// windows are driven and compared when the DUT presents a result.
module tb_max_exp_sched;

`ifdef MAX_EXP_SCHED_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  max_exp_sched_if #(.EXP_W(6), .CNT_W(8)) bus ();

  max_exp_sched #(.EXP_W(6), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] mx;
    logic       all;
  } res_t;

  res_t        sb[$];
  logic [53:0] win_e[$];
  logic [8:0]  win_s[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [53:0] pack9(input int a1, a2, a3, a4, a5, a6, a7, a8, a9);
    logic [5:0] v [9];
    logic [53:0] r;
    v[0] = a1[5:0]; v[1] = a2[5:0]; v[2] = a3[5:0]; v[3] = a4[5:0]; v[4] = a5[5:0];
    v[5] = a6[5:0]; v[6] = a7[5:0]; v[7] = a8[5:0]; v[8] = a9[5:0];
    for (int i = 0; i < 9; i++) r[(8-i)*6 +: 6] = v[i];
    return r;
  endfunction

  // Reference: plain linear scan over unmasked lanes.
  function automatic logic [5:0] win_max(input logic [53:0] e, input logic [8:0] s);
    logic [5:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) begin
      if (!s[i] && e[i*6 +: 6] > m) m = e[i*6 +: 6];
    end
    return m;
  endfunction

  task automatic add_win(input logic [53:0] e, input logic [8:0] s);
    win_e.push_back(e);
    win_s.push_back(s);
  endtask

  // Present one window; stall count must be zero when expect_nostall is set.
  task automatic send_win(input logic [53:0] e, input logic [8:0] s, input bit expect_nostall);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_exp   = e;
    bus.in_skip  = s;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    if (expect_nostall) chk("throughput_stall", n, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Drive all queued windows as one block, then check the result and handshake.
  task automatic run_block(input int cfg, input int cfg_mid, input int hold);
    res_t exp_r;
    res_t got_r;
    int   nw;
    int   lat;
    exp_r.mx  = '0;
    exp_r.all = 1'b1;
    nw = win_e.size();
    for (int i = 0; i < nw; i++) begin
      if (win_max(win_e[i], win_s[i]) > exp_r.mx) exp_r.mx = win_max(win_e[i], win_s[i]);
      exp_r.all = exp_r.all & (&win_s[i]);
    end
    sb.push_back(exp_r);
    bus.cfg_groups = cfg[7:0];
    for (int i = 0; i < nw; i++) begin
      send_win(win_e[i], win_s[i], i > 0);
      if (i == 0) bus.cfg_groups = cfg_mid[7:0];
    end
    win_e.delete();
    win_s.delete();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, LAT);
    chk("in_ready_in_done", bus.in_ready, 0);
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      exp_r = sb.pop_front();
      got_r.mx  = bus.out_max_exp;
      got_r.all = bus.out_all_skip;
      chk("out_max_exp", got_r.mx, exp_r.mx);
      chk("out_all_skip", got_r.all, exp_r.all);
    end
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_exp    = pack9(63, 63, 63, 63, 63, 63, 63, 63, 63);
      bus.in_skip   = '0;
      @(posedge clk);
      #1;
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_out_max_exp", bus.out_max_exp, exp_r.mx);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("handshake_out_valid", bus.out_valid, 0);
    chk("post_handshake_in_ready", bus.in_ready, 1);
    chk("post_handshake_busy", bus.busy, 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.cfg_groups = 8'd1;
    bus.in_valid   = 1'b0;
    bus.in_exp     = '0;
    bus.in_skip    = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_max_exp", bus.out_max_exp, 0);
    chk("rst_out_all_skip", bus.out_all_skip, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 1);

    // Single group, mixed values.
    add_win(pack9(3, 7, 12, 1, 0, 5, 9, 2, 4), 9'b0);
    run_block(1, 1, 0);

    // Three groups back to back, with output backpressure for 4 cycles.
    add_win(pack9(10, 1, 2, 3, 4, 5, 6, 7, 8), 9'b0);
    add_win(pack9(1, 2, 3, 4, 30, 5, 6, 7, 8), 9'b0);
    add_win(pack9(0, 0, 0, 0, 0, 0, 0, 0, 17), 9'b0);
    run_block(3, 3, 4);

    // Skipped lane 3 carries the largest value.
    add_win(pack9(1, 2, 40, 8, 3, 0, 7, 5, 6), 9'b001000000);
    run_block(1, 1, 0);

    // Everything skipped over two groups.
    add_win(pack9(50, 50, 50, 50, 50, 50, 50, 50, 50), 9'h1FF);
    add_win(pack9(9, 9, 9, 9, 9, 9, 9, 9, 9), 9'h1FF);
    run_block(2, 2, 0);

    // cfg_groups = 0 acts as 1; lane 9 holds the maximum, lane 1 skipped.
    add_win(pack9(62, 1, 2, 3, 4, 5, 6, 7, 63), 9'b100000000);
    run_block(0, 0, 0);

    // cfg_groups changed mid-block is ignored; only the second window is fully skipped.
    add_win(pack9(5, 0, 0, 0, 0, 0, 0, 0, 0), 9'b0);
    add_win(pack9(20, 20, 20, 20, 20, 20, 20, 20, 20), 9'h1FF);
    run_block(2, 5, 0);

    // Reset in the middle of a 4-group block.
    bus.cfg_groups = 8'd4;
    send_win(pack9(55, 0, 0, 0, 0, 0, 0, 0, 0), 9'b0, 1'b0);
    send_win(pack9(0, 0, 0, 0, 0, 0, 0, 0, 60), 9'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out_max_exp", bus.out_max_exp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    add_win(pack9(2, 21, 3, 4, 5, 6, 7, 8, 9), 9'b0);
    run_block(1, 1, 0);

    // Full-scale group count with random windows.
    for (int i = 0; i < 255; i++) begin
      add_win({$urandom, $urandom}, $urandom_range(0, 511));
    end
    run_block(255, 255, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
